// File: rtl/fb_pkg.sv
// Shared types and default sizes for the frame-buffer arbiter.
package fb_pkg;

  localparam int unsigned FB_ADDR_W     = 15;
  localparam int unsigned FB_DATA_W     = 16;
  localparam int unsigned FB_WBUF_DEPTH = 8;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_DISP,
    GNT_WR
  } grant_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write-buffer FIFO; DEPTH must be a power of two so pointers wrap naturally.
module fb_wr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 31,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even while it is popping in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, writer words drain from a FIFO.
// FB_DOUBLE_BUF_EN enables two banks with frame-synchronous swapping.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W     = FB_ADDR_W,
  parameter int unsigned DATA_W     = FB_DATA_W,
  parameter int unsigned WBUF_DEPTH = FB_WBUF_DEPTH
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              frame_start,
  input  logic              swap_req,
  output logic              bank_sel,
  output logic              idle,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(WBUF_DEPTH) + 1;

  grant_e             gnt;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   count;
  logic               rd_bank;
  logic               wr_bank;
  logic               rvalid_q;
  logic [ADDR_W:0]    addr_q;

  assign wr_ready = !full;
  assign push     = wr_valid && wr_ready;
  assign pop      = (gnt == GNT_WR);
  assign idle     = (count == '0);

  fb_wr_fifo #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .din   ({wr_addr, wr_data}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    gnt = GNT_IDLE;
    if (disp_req)    gnt = GNT_DISP;
    else if (!empty) gnt = GNT_WR;
  end

  // RAM port drive; an idle cycle keeps the previous address on the bus.
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (gnt)
      GNT_DISP: mem_addr = {rd_bank, disp_addr};
      GNT_WR: begin
        mem_addr  = {wr_bank, head[ENTRY_W-1:DATA_W]};
        mem_we    = 1'b1;
        mem_wdata = head[DATA_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rvalid_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      rvalid_q <= (gnt == GNT_DISP);
      addr_q   <= mem_addr;
    end
  end

  // The RAM output register already holds the data; only qualify it with the valid flag.
  assign disp_rvalid = rvalid_q;
  assign disp_rdata  = rvalid_q ? mem_rdata : '0;

`ifdef FB_DOUBLE_BUF_EN
  logic bank_q;
  logic swap_pend;

  // Swap only at a frame boundary with nothing queued for the back bank.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bank_q    <= 1'b0;
      swap_pend <= 1'b0;
    end else if (frame_start && (swap_pend || swap_req) && idle) begin
      bank_q    <= ~bank_q;
      swap_pend <= 1'b0;
    end else if (swap_req) begin
      swap_pend <= 1'b1;
    end
  end

  assign rd_bank  = bank_q;
  assign wr_bank  = ~bank_q;
  assign bank_sel = bank_q;
`else
  logic unused_swap;
  assign unused_swap = ^{swap_req, frame_start};
  assign rd_bank     = 1'b0;
  assign wr_bank     = 1'b0;
  assign bank_sel    = 1'b0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a read/write scoreboard; define FB_DOUBLE_BUF_EN to cover bank swapping.
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int unsigned AW = FB_ADDR_W;
  localparam int unsigned DW = FB_DATA_W;

  logic          clk;
  logic          nrst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_start;
  logic          swap_req;
  logic          bank_sel;
  logic          idle;
  logic [AW:0]   mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  fb_arbiter dut (
    .clk         (clk),
    .nrst        (nrst),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_start (frame_start),
    .swap_req    (swap_req),
    .bank_sel    (bank_sel),
    .idle        (idle),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous read returning the address as data.
  always @(posedge clk) mem_rdata <= DW'(mem_addr);

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model and scoreboards, advanced at every falling edge.
  wbuf_entry_t   wq[$];
  logic [DW-1:0] rq[$];
  int            m_cnt  = 0;
  logic          m_rv   = 1'b0;
  logic          m_bank = 1'b0;
  logic          m_pend = 1'b0;
  logic          mon_rd;
  logic          mon_wr;
  logic          mon_push;
  logic          mon_wbank;
  wbuf_entry_t   mon_e;
  logic [DW-1:0] mon_rexp;

  always @(negedge clk) begin
    if (!nrst) begin
      check("rst_wr_ready", wr_ready, 1);
      check("rst_idle", idle, 1);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_rvalid", disp_rvalid, 0);
      check("rst_rdata", disp_rdata, 0);
      check("rst_bank_sel", bank_sel, 0);
      wq.delete();
      rq.delete();
      m_cnt  = 0;
      m_rv   = 1'b0;
      m_bank = 1'b0;
      m_pend = 1'b0;
    end else begin
      mon_rd = disp_req;
      mon_wr = !disp_req && (m_cnt != 0);
`ifdef FB_DOUBLE_BUF_EN
      mon_wbank = ~m_bank;
`else
      mon_wbank = 1'b0;
`endif
      check("wr_ready", wr_ready, m_cnt != 8);
      check("idle", idle, m_cnt == 0);
      check("bank_sel", bank_sel, m_bank);
      check("mem_we", mem_we, mon_wr);
      check("rvalid", disp_rvalid, m_rv);
      if (m_rv && rq.size() != 0) begin
        mon_rexp = rq.pop_front();
        check("rdata", disp_rdata, mon_rexp);
      end
      if (mon_rd) begin
        check("rd_addr", mem_addr, {m_bank, disp_addr});
        rq.push_back({m_bank, disp_addr});
      end
      if (mon_wr) begin
        mon_e = wq.pop_front();
        check("wr_addr", mem_addr, {mon_wbank, mon_e.addr});
        check("wr_data", mem_wdata, mon_e.data);
      end
`ifdef FB_DOUBLE_BUF_EN
      if (frame_start && (m_pend || swap_req) && m_cnt == 0) begin
        m_bank = ~m_bank;
        m_pend = 1'b0;
      end else if (swap_req) begin
        m_pend = 1'b1;
      end
`endif
      mon_push = wr_valid && (m_cnt != 8);
      if (mon_push) wq.push_back({wr_addr, wr_data});
      m_cnt = m_cnt + (mon_push ? 1 : 0) - (mon_wr ? 1 : 0);
      m_rv  = mon_rd;
    end
  end

  // Per-cycle observations captured mid-cycle by step().
  logic hs;
  logic we_s;
  logic msb_s;
  logic rv_s;

  task automatic step();
    @(negedge clk);
    hs    = wr_valid && wr_ready;
    we_s  = mem_we;
    msb_s = mem_addr[AW];
    rv_s  = disp_rvalid;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i);
    wr_addr = AW'(32'h0100 + i);
    wr_data = DW'(32'hA000 + i);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 30; c++) begin
      if (idle) break;
      step();
    end
    check(tag, idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_acc;
  int n_we;
  int n_rv;
  int widx;

  initial begin
    nrst        = 1'b0;
    disp_req    = 1'b0;
    disp_addr   = '0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    frame_start = 1'b0;
    swap_req    = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    #1;
    check("post_rst_wr_ready", wr_ready, 1);
    check("post_rst_idle", idle, 1);
    check("post_rst_mem_we", mem_we, 0);
    check("post_rst_bank_sel", bank_sel, 0);
    check("post_rst_rvalid", disp_rvalid, 0);
    step();

    // Read latency, then a back-to-back burst.
    disp_req  = 1'b1;
    disp_addr = AW'(16'h0123);
    step();
    disp_req = 1'b0;
    check("rd_lat_rvalid", disp_rvalid, 1);
    check("rd_lat_rdata", disp_rdata, 16'h0123);
    step();
    n_rv = 0;
    for (int c = 0; c <= 10; c++) begin
      disp_req  = (c < 10);
      disp_addr = AW'(32'h0400 + 3 * c);
      step();
      if (c > 0 && rv_s) n_rv++;
    end
    check("rd_burst_count", n_rv, 10);

    // Priority: display holds the RAM while the writer offers 12 words.
    n_acc = 0;
    n_we  = 0;
    widx  = 0;
    disp_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      disp_addr = AW'(32'h0200 + c);
      wr_valid  = (widx < 12);
      set_word(widx);
      step();
      if (hs) begin
        n_acc++;
        widx++;
      end
      if (we_s) n_we++;
    end
    check("prio_accepted", n_acc, 8);
    check("prio_no_we", n_we, 0);
    check("prio_ready_low", wr_ready, 0);
    disp_req = 1'b0;
    n_we = 0;
    for (int c = 0; c < 40; c++) begin
      if (widx == 12 && idle) break;
      wr_valid = (widx < 12);
      set_word(widx);
      step();
      if (hs) widx++;
      if (we_s) n_we++;
    end
    wr_valid = 1'b0;
    check("prio_all_pushed", widx, 12);
    check("prio_drain_writes", n_we, 12);
    check("prio_idle", idle, 1);

    // Full boundary: a popping full FIFO still refuses the offered word.
    disp_req = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_word(32 + i);
      step();
    end
    disp_req = 1'b0;
    set_word(40);
    step();
    check("full_no_push", hs, 0);
    check("full_pop_we", we_s, 1);
    check("full_ready_rise", wr_ready, 1);
    step();
    check("full_push_next", hs, 1);
    wr_valid = 1'b0;
    drain("full_drain_idle");

    // Reset mid-drain discards queued writes and a pending read valid.
    disp_req = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_word(64 + i);
      step();
    end
    wr_valid  = 1'b0;
    disp_addr = AW'(16'h0777);
    step();
    disp_req = 1'b0;
    nrst     = 1'b0;
    #1;
    check("rst_mid_rvalid", disp_rvalid, 0);
    check("rst_mid_idle", idle, 1);
    step();
    nrst = 1'b1;
    n_we = 0;
    n_rv = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (we_s) n_we++;
      if (rv_s) n_rv++;
    end
    check("rst_mid_no_we", n_we, 0);
    check("rst_mid_no_rvalid", n_rv, 0);
    check("rst_mid_idle_after", idle, 1);

`ifdef FB_DOUBLE_BUF_EN
    // Swap with an empty FIFO, then writes target bank 0.
    swap_req = 1'b1;
    step();
    swap_req    = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("swap_toggle", bank_sel, 1);
    wr_valid = 1'b1;
    set_word(80);
    step();
    wr_valid = 1'b0;
    step();
    check("swap_wr_we", we_s, 1);
    check("swap_wr_bank", msb_s, 0);

    // Swap requested with 3 words queued is deferred until drained.
    disp_req = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_word(96 + i);
      step();
    end
    wr_valid = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req    = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("swap_deferred", bank_sel, 1);
    disp_req = 1'b0;
    drain("swap_drain_idle");
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("swap_after_drain", bank_sel, 0);
`else
    // Single bank: swap controls are ignored and writes stay in bank 0.
    swap_req    = 1'b1;
    frame_start = 1'b1;
    step();
    swap_req    = 1'b0;
    frame_start = 1'b0;
    check("single_bank_sel", bank_sel, 0);
    wr_valid = 1'b1;
    set_word(80);
    step();
    wr_valid = 1'b0;
    step();
    check("single_wr_we", we_s, 1);
    check("single_wr_bank", msb_s, 0);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between two requesters:
  - the VGA scan-out reader, which has hard-deadline reads;
  - the edge-detection result writer, which uses a valid/ready stream.
- Display reads always win. Writer traffic is absorbed by a small write FIFO and drained in cycles where the display does not read, mainly blanking.
- Sits between the vgaController pixel fetch and the RAM macro, in the same clock domain as the display.

Parameters:
- ADDR_W, 15, word address width of one frame bank.
- DATA_W, 16, RAM word width.
- WBUF_DEPTH, 8, write FIFO entries; must be a power of 2 and ≥2.

Ports:
- clk  in  1  single clock shared with display timing.
- nrst  in  1  asynchronous active-low reset.
- disp_req  in  1  display read request this cycle.
- disp_addr  in  ADDR_W  display read word address.
- disp_rvalid  out  1  read data valid; one cycle after grant.
- disp_rdata  out  DATA_W  read data.
- wr_valid  in  1  writer has a word.
- wr_ready  out  1  FIFO can accept a word.
- wr_addr  in  ADDR_W  writer word address.
- wr_data  in  DATA_W  writer word.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- swap_req  in  1  pulse: writer finished a frame.
- bank_sel  out  1  bank currently displayed.
- idle  out  1  FIFO empty and no write in flight.
- mem_addr  out  ADDR_W+1  RAM address; MSB is the bank.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; synchronous, 1-cycle latency.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset nrst is asynchronous, active-low.
  - Reset values: FIFO empty, count=0, disp_rvalid=0, disp_rdata=0, bank_sel=0, swap pending=0, mem_we=0, mem_addr=0, idle=1, wr_ready=1.
- Grant: combinational per cycle, priority DISP > WR > IDLE.
  - DISP (disp_req=1): mem_addr={rd_bank,disp_addr}, mem_we=0.
  - WR (disp_req=0 and FIFO non-empty): mem_addr={wr_bank,head.addr}, mem_wdata=head.data, mem_we=1, FIFO pops.
  - IDLE: mem_we=0, mem_addr holds last value.
- Read path:
  - Registered grant flag gives disp_rvalid exactly 1 cycle after a DISP cycle.
  - disp_rdata = mem_rdata, registered as a passthrough of the sync RAM output.
  - Back-to-back reads are sustained at 1 per cycle with no bubbles.
- FIFO:
  - Push on wr_valid&&wr_ready. wr_ready = (count != WBUF_DEPTH), taken from registered count only.
  - A full FIFO never accepts, even when popping the same cycle; wr_ready rises the following cycle.
  - Simultaneous push and pop when not full: count is unchanged, data order preserved.
  - Pointers wrap modulo WBUF_DEPTH.
- Hazard: a display read of an address still queued in the FIFO returns the old RAM contents. This is intended; no forwarding.
- Starvation: writer may starve indefinitely while disp_req is held. No timeout.
- Reset mid-operation: queued writes are discarded. A read granted the cycle before reset produces no rvalid.
- idle = (count==0).

Optional Feature:
- Macro: FB_DOUBLE_BUF_EN.
- Defined:
  - Two banks. rd_bank=bank_sel, wr_bank=~bank_sel.
  - swap_req sets swap_pend.
  - On frame_start with swap_pend=1 and count==0: bank_sel toggles and swap_pend clears, effective next cycle.
  - If count!=0 at frame_start: defer to the next frame_start.
  - swap_req and frame_start in the same cycle: the swap happens at that frame_start only if count==0.
- Not defined:
  - Single bank; both bank bits tie to 0; bank_sel=0.
  - swap_req and frame_start are ignored. Ports remain present.

Decomposition:
- Package fb_pkg:
  - ADDR_W/DATA_W default constants.
  - typedef struct packed {addr, data} wbuf_entry_t.
  - typedef enum {GNT_IDLE, GNT_DISP, GNT_WR} grant_e.
- Sub-module fb_wr_fifo: parameterized synchronous FIFO.
  - Ports: push, pop, din, dout, count, full, empty.
  - fb_arbiter owns the grant, read-valid and bank logic only.

Test Plan:
- Reset, then release with all inputs 0 → wr_ready=1, idle=1, mem_we=0, bank_sel=0, disp_rvalid=0.
- Read latency, with a RAM model returning address as data: disp_req with addr 0x0123 → disp_rvalid=1 next cycle, disp_rdata=0x0123. Then 10 back-to-back reads → 10 consecutive rvalids.
- Priority: hold disp_req for 20 cycles while the writer offers 12 words. Required response:
  - exactly 8 accepted; wr_ready=0 from the cycle after the 8th push;
  - mem_we=0 throughout;
  - after disp_req drops, 8 consecutive writes in push order, then 4 more, then idle=1.
- Full boundary: FIFO full, disp_req=0, wr_valid=1 → no push that cycle, count 7 after the pop, wr_ready=1 next cycle, push accepted.
- Reset mid-drain: 5 entries queued, assert nrst for one cycle → count=0, no further mem_we, idle=1.
- With FB_DOUBLE_BUF_EN:
  - swap_req, then frame_start with count==0 → bank_sel 0→1, writes go to MSB=0.
  - Repeat with count=3 → no toggle; toggle at the following frame_start once drained.
